// File: rtl/apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// apb_regfile_slave
// APB4 slave in front of a word-addressed register bank. The low RO_BASE
// registers are software read/write and appear on rw_out. The registers from
// RO_BASE up to NUM_REGS-1 are read-only mirrors of ro_in. The slave supports
// a fixed number of wait states, byte strobes and PSLVERR.
//
// Ports
//   PCLK, PRESETn     clock (rising edge), asynchronous active-low reset
//   PSEL, PENABLE     APB select and access-phase qualifier
//   PWRITE, PADDR     transfer direction and byte address
//   PWDATA, PSTRB     write data and byte-lane strobes
//   PREADY            registered; high only in the last access cycle
//   PRDATA, PSLVERR   registered; valid with PREADY, zero otherwise
//   ro_in             packed read-only values, register RO_BASE in the LSBs
//   rw_out            packed read/write register contents, register 0 in the LSBs
// -----------------------------------------------------------------------------
module apb_regfile_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned RO_BASE     = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                                  PCLK,
  input  logic                                  PRESETn,
  input  logic                                  PSEL,
  input  logic                                  PENABLE,
  input  logic                                  PWRITE,
  input  logic [ADDR_WIDTH-1:0]                 PADDR,
  input  logic [DATA_WIDTH-1:0]                 PWDATA,
  input  logic [DATA_WIDTH/8-1:0]               PSTRB,
  output logic                                  PREADY,
  output logic [DATA_WIDTH-1:0]                 PRDATA,
  output logic                                  PSLVERR,
  // One dummy word keeps the port legal when there are no read-only registers
  input  logic [((NUM_REGS > RO_BASE) ? (NUM_REGS - RO_BASE) : 1)*DATA_WIDTH-1:0] ro_in,
  output logic [RO_BASE*DATA_WIDTH-1:0]         rw_out
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RO_CNT = NUM_REGS - RO_BASE;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e                 state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [IDX_W-1:0]       idx_q,     idx_d;
  logic                   wr_q,      wr_d;
  logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;
  logic [STRB_W-1:0]      strb_q,    strb_d;
  logic                   pready_q,  pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]  prdata_q,  prdata_d;
  logic [DATA_WIDTH-1:0]  regs_q [RO_BASE];
  logic [DATA_WIDTH-1:0]  regs_d [RO_BASE];

  logic [IDX_W-1:0]       live_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_wr;
  logic                   sel_err;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic                   respond;
  logic                   unused_addr_bits;

  // Byte offset bits inside a word carry no information
  assign live_idx         = PADDR[ADDR_WIDTH-1:OFFS_W];
  assign unused_addr_bits = ^PADDR;

  // With zero wait states the response is built from the live setup-phase
  // inputs, otherwise from the values latched at setup.
  assign sel_idx = (state_q == S_IDLE) ? live_idx : idx_q;
  assign sel_wr  = (state_q == S_IDLE) ? PWRITE   : wr_q;
  assign sel_err = (32'(sel_idx) >= NUM_REGS) ||
                   (sel_wr && (32'(sel_idx) >= RO_BASE));

  // Read mux over the RW bank and the RO mirror
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(RO_BASE); i++) begin
      if (sel_idx == IDX_W'(i)) rd_word = regs_q[i];
    end
    for (int i = 0; i < int'(RO_CNT); i++) begin
      if (sel_idx == IDX_W'(int'(RO_BASE) + i)) rd_word = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, response and write-commit logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    regs_d    = regs_q;
    respond   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A lone PENABLE without a preceding setup cycle is ignored here
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          idx_d   = live_idx;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          respond = (WAIT_CYCLES == 0);
        end
      end
      S_ACCESS: begin
        if (pready_q) begin
          // Edge closing the PREADY cycle: commit and return to idle
          state_d = S_IDLE;
          cnt_d   = '0;
          if (wr_q && !pslverr_q) begin
            for (int i = 0; i < int'(RO_BASE); i++) begin
              if (idx_q == IDX_W'(i)) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                  if (strb_q[b]) regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                end
              end
            end
          end
        end else if (!PSEL) begin
          // Master dropped the transfer during wait states
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          respond = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (respond) begin
      pready_d  = 1'b1;
      pslverr_d = sel_err;
      prdata_d  = (!sel_wr && !sel_err) ? rd_word : '0;
    end
  end

  // State and bank registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < int'(RO_BASE); i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

  // Pack the RW bank, register 0 in the LSBs
  always_comb begin
    rw_out = '0;
    for (int i = 0; i < int'(RO_BASE); i++) begin
      rw_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_regfile_slave
// Directed bench for apb_regfile_slave. Three instances (0, 2 and 3 wait
// states) share the APB bus signals and have separate PSEL lines.
// -----------------------------------------------------------------------------
module tb_apb_regfile_slave;

  logic          pclk;
  logic          presetn;
  logic [3:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [7:0]    paddr;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [127:0]  ro_in;
  logic [3:0]    pready;
  logic [3:0]    pslverr;
  logic [31:0]   prdata [4];
  logic [383:0]  rw_out [4];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rdata;
  logic [31:0] first_rd;
  logic        err;
  int          lat;
  logic        saw_ready;

  apb_regfile_slave #(.WAIT_CYCLES(0)) u_dut_w0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .ro_in(ro_in), .rw_out(rw_out[0])
  );

  apb_regfile_slave #(.WAIT_CYCLES(2)) u_dut_w2 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]),
    .ro_in(ro_in), .rw_out(rw_out[2])
  );

  apb_regfile_slave #(.WAIT_CYCLES(3)) u_dut_w3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[3]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[3]), .PRDATA(prdata[3]), .PSLVERR(pslverr[3]),
    .ro_in(ro_in), .rw_out(rw_out[3])
  );

  // Unused slot 1 keeps indices equal to the wait-state count
  assign pready[1]  = 1'b0;
  assign pslverr[1] = 1'b0;
  assign prdata[1]  = '0;
  assign rw_out[1]  = '0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One complete transfer; returns in the PREADY cycle so a following call is back-to-back
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          output logic [31:0] rd, output logic e, output int l,
                          output logic [31:0] first);
    @(posedge pclk); #1;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    l       = 1;
    first   = prdata[d];
    while (!pready[d] && l < 40) begin
      @(posedge pclk); #1;
      l++;
    end
    check("pready_seen", 32'(pready[d]), 32'd1);
    rd = prdata[d];
    e  = pslverr[d];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel    = '0;
      penable = 1'b0;
    end
  endtask

  initial begin
    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    ro_in   = {32'h4444_0015, 32'h3333_0014, 32'hBEEF_0013, 32'hCAFE_0001};

    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready",  32'(pready[0]),  32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_prdata",  prdata[0],       32'd0);
    check("rst_rw_out",  rw_out[0][31:0], 32'd0);
    presetn = 1'b1;

    // Reset in the middle of a 2-wait-state write
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h00; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check("w2_not_ready_yet", 32'(pready[2]), 32'd0);
    presetn = 1'b0;
    #1;
    check("midrst_pready", 32'(pready[2]), 32'd0);
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    saw_ready = 1'b0;
    repeat (4) begin
      @(posedge pclk); #1;
      saw_ready = saw_ready | pready[2];
    end
    check("midrst_no_ready",  32'(saw_ready),   32'd0);
    check("midrst_no_commit", rw_out[2][31:0],  32'd0);

    // Normal 2-wait-state write
    apb_xfer(2, 1'b1, 8'h00, 32'hA5A5_A5A5, 4'hF, rdata, err, lat, first_rd);
    check("w2_lat", 32'(lat), 32'd3);
    check("w2_err", 32'(err), 32'd0);
    idle(1);
    check("w2_commit", rw_out[2][31:0], 32'hA5A5_A5A5);

    // Zero-wait write then back-to-back read
    apb_xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, rdata, err, lat, first_rd);
    check("w0_wr_lat", 32'(lat), 32'd1);
    check("w0_wr_err", 32'(err), 32'd0);
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("w0_rd_lat",  32'(lat), 32'd1);
    check("w0_rd_data", rdata,    32'hDEAD_BEEF);
    check("w0_rd_err",  32'(err), 32'd0);

    // Byte strobes 0101
    apb_xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'b0101, rdata, err, lat, first_rd);
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("strb_rd", rdata, 32'hDE22_BE44);
    idle(1);
    check("strb_rw_out", rw_out[0][63:32], 32'hDE22_BE44);
    check("idle_prdata", prdata[0],        32'd0);

    // Errors: write to RO, read/write out of range
    apb_xfer(0, 1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF, rdata, err, lat, first_rd);
    check("ro_wr_err", 32'(err), 32'd1);
    apb_xfer(0, 1'b0, 8'h30, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("ro_rd_data", rdata,    32'hCAFE_0001);
    check("ro_rd_err",  32'(err), 32'd0);
    apb_xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("oor_rd_err",  32'(err), 32'd1);
    check("oor_rd_data", rdata,    32'd0);
    apb_xfer(0, 1'b1, 8'h40, 32'h5555_5555, 4'hF, rdata, err, lat, first_rd);
    check("oor_wr_err", 32'(err), 32'd1);

    // Zero strobe write: no change, no error
    apb_xfer(0, 1'b1, 8'h08, 32'h9999_9999, 4'h0, rdata, err, lat, first_rd);
    check("strb0_err", 32'(err), 32'd0);
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("strb0_rd", rdata, 32'd0);
    idle(1);

    // Three wait states, RO reads
    apb_xfer(3, 1'b0, 8'h30, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("w3_lat",      32'(lat), 32'd4);
    check("w3_early_rd", first_rd, 32'd0);
    check("w3_rd_data",  rdata,    32'hCAFE_0001);
    check("w3_rd_err",   32'(err), 32'd0);
    apb_xfer(3, 1'b0, 8'h34, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("w3_rd13", rdata, 32'hBEEF_0013);
    idle(1);

    // Abort: drop PSEL in the second wait cycle of a write to reg 2
    @(posedge pclk); #1;
    psel[3] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    saw_ready = 1'b0;
    repeat (6) begin
      @(posedge pclk); #1;
      saw_ready = saw_ready | pready[3];
    end
    check("abort_no_ready", 32'(saw_ready),  32'd0);
    check("abort_reg2",     rw_out[3][95:64], 32'd0);

    // PENABLE without a setup cycle
    psel[3] = 1'b1; penable = 1'b1; pwrite = 1'b1;
    saw_ready = 1'b0;
    repeat (3) begin
      @(posedge pclk); #1;
      saw_ready = saw_ready | pready[3];
    end
    psel = '0; penable = 1'b0;
    repeat (5) begin
      @(posedge pclk); #1;
      saw_ready = saw_ready | pready[3];
    end
    check("penable_only_ignored", 32'(saw_ready), 32'd0);
    apb_xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, rdata, err, lat, first_rd);
    check("abort_rd_reg2", rdata, 32'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
